// File: rtl/choice_update_ctrl.sv
// choice_update_ctrl: the only writer of the tournament predictor's 2-bit
// choice table. After reset or flush it sweeps every entry to INIT_VAL. It then
// drains a small FIFO of resolved-branch updates from WB. Each update is a
// 2-cycle read-modify-write (RD, WR) through the table's single write port.
// Optional build macro: CHOICE_UPD_FILTER_EN. When it is defined, updates that
// carry no direction are never queued and never counted as drops.
module choice_update_ctrl #(
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter logic [1:0]  INIT_VAL = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [15:0]      wb_pcplus2,
  input  logic             lc_correct,
  input  logic             gl_correct,
  input  logic [1:0]       tbl_rdata,
  output logic [IDX_W-1:0] tbl_idx,
  output logic [1:0]       tbl_wdata,
  output logic             tbl_we,
  output logic             init_done,
  output logic             q_full,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = IDX_W + 2;

  localparam logic [1:0]       DirNone   = 2'b00;
  localparam logic [1:0]       DirUp     = 2'b01;
  localparam logic [1:0]       DirDn     = 2'b10;
  localparam logic [IDX_W-1:0] SweepLast = '1;
  localparam logic [IDX_W-1:0] IdxOne    = IDX_W'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);
  localparam logic [PTR_W:0]   CntOne    = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CntFull   = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StInit, StIdle, StRd, StWr} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [ENT_W-1:0]   fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               q_full_q;
  logic [7:0]         drop_q;
  logic               init_done_q;
  logic [1:0]         rdata_q;

  logic [IDX_W-1:0]   wb_idx;
  logic [1:0]         wb_dir;
  logic               wb_keep;
  logic               enq, drop, pop;
  logic [IDX_W-1:0]   head_idx;
  logic [1:0]         head_dir;
  logic [1:0]         upd_val;

  // Only the low IDX_W bits of PC-2 form the index.
  assign wb_idx = wb_pcplus2[IDX_W-1:0] - IDX_W'(2);
  if (IDX_W < 16) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^wb_pcplus2[15:IDX_W];
  end

  assign wb_dir = (lc_correct && !gl_correct) ? DirUp :
                  (!lc_correct && gl_correct) ? DirDn : DirNone;

`ifdef CHOICE_UPD_FILTER_EN
  assign wb_keep = (wb_dir != DirNone);
`else
  assign wb_keep = 1'b1;
`endif

  // flush overrides every FIFO event; a WR in the flush cycle writes but does not pop
  assign enq  = wb_valid && wb_keep && !q_full_q && !flush;
  assign drop = wb_valid && wb_keep && q_full_q && !flush;
  assign pop  = (state_q == StWr) && !flush;

  assign head_idx = fifo_q[rd_ptr_q][ENT_W-1:2];
  assign head_dir = fifo_q[rd_ptr_q][1:0];

  // Next FIFO occupancy
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (enq && !pop) begin
      count_d = count_q + CntOne;
    end else if (!enq && pop) begin
      count_d = count_q - CntOne;
    end
  end

  // Saturating update of the captured entry
  always_comb begin
    upd_val = rdata_q;
    if (head_dir == DirUp && rdata_q != 2'b11) begin
      upd_val = rdata_q + 2'b01;
    end else if (head_dir == DirDn && rdata_q != 2'b00) begin
      upd_val = rdata_q - 2'b01;
    end
  end

  // FSM next state and table port drive
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    tbl_we    = 1'b0;
    tbl_idx   = head_idx;
    tbl_wdata = INIT_VAL;
    unique case (state_q)
      StInit: begin
        tbl_we  = 1'b1;
        tbl_idx = sweep_q;
        sweep_d = sweep_q + IdxOne;
        if (sweep_q == SweepLast) state_d = StIdle;
      end
      StIdle: begin
        tbl_idx = (count_q != '0) ? head_idx : '0;
        if (count_d != '0) state_d = StRd;
      end
      StRd: begin
        state_d = StWr;
      end
      StWr: begin
        tbl_we    = 1'b1;
        tbl_wdata = upd_val;
        state_d   = (count_d != '0) ? StRd : StIdle;
      end
      default: state_d = StInit;
    endcase
    if (flush) begin
      state_d = StInit;
      sweep_d = '0;
    end
  end

  // FSM, sweep pointer and init flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      if (flush) begin
        init_done_q <= 1'b0;
      end else if (state_q == StInit && sweep_q == SweepLast) begin
        init_done_q <= 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy, full flag, drop counter and RD capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_full_q <= 1'b0;
      drop_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + PtrOne;
        if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      count_q  <= count_d;
      q_full_q <= (count_d == CntFull);
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (state_q == StRd) rdata_q <= tbl_rdata;
    end
  end

  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (enq) fifo_q[wr_ptr_q] <= {wb_idx, wb_dir};
  end

  assign init_done = init_done_q;
  assign q_full    = q_full_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_choice_update_ctrl.sv
// Bench for choice_update_ctrl. The bench owns the choice table memory and
// keeps a transaction-level model: an ordered queue of pending updates, a
// reference table image and a drop count.
module tb_choice_update_ctrl;

  localparam int IDX_W = 8;
  localparam int DEPTH = 4;
  localparam int N     = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wb_valid;
  logic [15:0] wb_pcplus2;
  logic        lc_correct;
  logic        gl_correct;
  logic [1:0]  tbl_rdata;
  logic [7:0]  tbl_idx;
  logic [1:0]  tbl_wdata;
  logic        tbl_we;
  logic        init_done;
  logic        q_full;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  choice_update_ctrl #(
    .IDX_W   (IDX_W),
    .DEPTH   (DEPTH),
    .INIT_VAL(2'b01)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wb_valid  (wb_valid),
    .wb_pcplus2(wb_pcplus2),
    .lc_correct(lc_correct),
    .gl_correct(gl_correct),
    .tbl_rdata (tbl_rdata),
    .tbl_idx   (tbl_idx),
    .tbl_wdata (tbl_wdata),
    .tbl_we    (tbl_we),
    .init_done (init_done),
    .q_full    (q_full),
    .drop_cnt  (drop_cnt)
  );

  // Choice table with a backdoor write port for preloading entries
  logic [1:0] tb_mem [N];
  logic       bd_we;
  logic [7:0] bd_idx;
  logic [1:0] bd_val;

  assign tbl_rdata = tb_mem[tbl_idx];

  always @(posedge clk) begin
    if (bd_we) tb_mem[bd_idx] <= bd_val;
    else if (tbl_we) tb_mem[tbl_idx] <= tbl_wdata;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  typedef struct {int idx; int dir;} upd_t;
  upd_t mq[$];
  int   ref_mem [N];
  int   m_drops   = 0;
  bit   model_on  = 0;
  bit   sweeping  = 1;
  int   sweep_idx = 0;

  function automatic int sat_apply(input int v, input int d);
    int r;
    r = v + d;
    if (r < 0) r = 0;
    if (r > 3) r = 3;
    return r;
  endfunction

  function automatic int dir_of(input logic lc, input logic gl);
    if (lc && !gl) return 1;
    if (!lc && gl) return -1;
    return 0;
  endfunction

  // Compare process: checks every cycle after reset release, then advances the model
  initial begin
    int   sz;
    int   d;
    int   ex;
    bit   keep;
    upd_t e;
    forever begin
      @(negedge clk);
      if (model_on) begin
        sz = mq.size();
        chk("q_full", int'(q_full), int'(sz == DEPTH));
        chk("drop_cnt", int'(drop_cnt), m_drops);
        if (bd_we) ref_mem[bd_idx] = int'(bd_val);
        if (sweeping) begin
          chk("sweep_we", int'(tbl_we), 1);
          chk("sweep_idx", int'(tbl_idx), sweep_idx);
          chk("sweep_wdata", int'(tbl_wdata), 1);
          chk("sweep_init_done", int'(init_done), 0);
          ref_mem[sweep_idx] = 1;
          sweep_idx++;
          if (sweep_idx == N) sweeping = 0;
        end else begin
          chk("init_done", int'(init_done), 1);
          if (tbl_we) begin
            if (sz == 0) begin
              chk("write_with_empty_queue", int'(tbl_we), 0);
            end else begin
              e  = mq.pop_front();
              ex = sat_apply(ref_mem[e.idx], e.dir);
              chk("wr_idx", int'(tbl_idx), e.idx);
              chk("wr_data", int'(tbl_wdata), ex);
              ref_mem[e.idx] = ex;
            end
          end
        end
        if (flush) begin
          mq.delete();
          sweeping  = 1;
          sweep_idx = 0;
        end else if (wb_valid) begin
          d = dir_of(lc_correct, gl_correct);
`ifdef CHOICE_UPD_FILTER_EN
          keep = (d != 0);
`else
          keep = 1'b1;
`endif
          if (keep) begin
            if (sz == DEPTH) begin
              if (m_drops < 255) m_drops++;
            end else begin
              e.idx = int'((wb_pcplus2 - 16'd2) & 16'h00FF);
              e.dir = d;
              mq.push_back(e);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the first cycle with init_done high; leaves us at that negedge
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!init_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(init_done), 1);
  endtask

  // One update into an idle controller: idle at t, RD at t+1, WR at t+2
  task automatic single_update(input string nm, input logic [15:0] pc, input logic lc,
                               input logic gl, input int eidx, input int ewd);
    tick();
    wb_valid   = 1'b1;
    wb_pcplus2 = pc;
    lc_correct = lc;
    gl_correct = gl;
    @(negedge clk);
    chk({nm, "_t_we"}, int'(tbl_we), 0);
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_rd_idx"}, int'(tbl_idx), eidx);
    chk({nm, "_rd_we"}, int'(tbl_we), 0);
    tick();
    @(negedge clk);
    chk({nm, "_wr_we"}, int'(tbl_we), 1);
    chk({nm, "_wr_idx"}, int'(tbl_idx), eidx);
    chk({nm, "_wr_data"}, int'(tbl_wdata), ewd);
  endtask

  initial begin
    int wq[$];
    int n;
    int mm;
    rst_n      = 1'b0;
    flush      = 1'b0;
    wb_valid   = 1'b0;
    wb_pcplus2 = '0;
    lc_correct = 1'b0;
    gl_correct = 1'b0;
    bd_we      = 1'b0;
    bd_idx     = '0;
    bd_val     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", int'(tbl_we), 1);
    chk("rst_idx", int'(tbl_idx), 0);
    chk("rst_wdata", int'(tbl_wdata), 1);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_q_full", int'(q_full), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    model_on = 1'b1;

    // Sweep: 256 write cycles, init_done rises on cycle 256
    repeat (256) @(negedge clk);
    chk("t1_last_idx", int'(tbl_idx), 255);
    chk("t1_done_low", int'(init_done), 0);
    @(negedge clk);
    chk("t1_done_rise", int'(init_done), 1);
    chk("t1_we_off", int'(tbl_we), 0);

    // Basic update: 0x3012 -> index 0x10, 01 + 1 = 10
    single_update("t2", 16'h3012, 1'b1, 1'b0, 8'h10, 2);

    // Saturation at both bounds
    tick();
    bd_we  = 1'b1;
    bd_idx = 8'h20;
    bd_val = 2'b11;
    tick();
    bd_idx = 8'h30;
    bd_val = 2'b00;
    tick();
    bd_we = 1'b0;
    single_update("t3_hi", 16'h0022, 1'b1, 1'b0, 8'h20, 3);
    single_update("t3_lo", 16'h0032, 1'b0, 1'b1, 8'h30, 0);

    // Overflow during the sweep: 6 pushes, 4 kept, 2 dropped
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_valid   = 1'b1;
      wb_pcplus2 = 16'h0052 + 16'(i);
      lc_correct = (i % 2 == 0);
      gl_correct = (i % 2 != 0);
      tick();
    end
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_q_full", int'(q_full), 1);
    chk("t4_drops", int'(drop_cnt), 2);
    wait_done("t4_init_done");
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tbl_we) wq.push_back(k);
    end
    chk("t4_nwrites", wq.size(), 4);
    for (int j = 0; j < wq.size() && j < 4; j++) chk("t4_wr_cycle", wq[j], 2 * j + 2);

    // Flush in RD with three entries queued and a concurrent wb_valid
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_valid   = 1'b1;
      wb_pcplus2 = 16'h0062 + 16'(i);
      lc_correct = 1'b1;
      gl_correct = 1'b0;
      tick();
    end
    wb_valid = 1'b0;
    wait_done("t5_init_done");
    tick();
    flush      = 1'b1;
    wb_valid   = 1'b1;
    wb_pcplus2 = 16'h0072;
    lc_correct = 1'b1;
    gl_correct = 1'b0;
    @(negedge clk);
    chk("t5_rd_we", int'(tbl_we), 0);
    chk("t5_rd_idx", int'(tbl_idx), 8'h60);
    tick();
    flush    = 1'b0;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t5_init_we", int'(tbl_we), 1);
    chk("t5_init_idx", int'(tbl_idx), 0);
    chk("t5_init_done", int'(init_done), 0);
    chk("t5_q_full", int'(q_full), 0);
    chk("t5_drops_kept", int'(drop_cnt), 2);
    wait_done("t5_resweep_done");
    repeat (6) begin
      @(negedge clk);
      chk("t5_quiet", int'(tbl_we), 0);
    end

    // No-direction updates
`ifdef CHOICE_UPD_FILTER_EN
    tick();
    wb_valid   = 1'b1;
    wb_pcplus2 = 16'h0042;
    lc_correct = 1'b1;
    gl_correct = 1'b1;
    tick();
    wb_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t6_no_rmw", int'(tbl_we), 0);
    end
`else
    single_update("t6_both", 16'h0042, 1'b1, 1'b1, 8'h40, 1);
    single_update("t6_none", 16'h0046, 1'b0, 1'b0, 8'h44, 1);
`endif

    // Drain and compare the table image
    n = 0;
    while ((mq.size() != 0 || tbl_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", mq.size(), 0);
    mm = 0;
    for (int i = 0; i < N; i++) if (int'(tb_mem[i]) != ref_mem[i]) mm++;
    chk("mem_image", mm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
